// File: rtl/dot_product_core.sv
// rtl/dot_product_core.sv - dot product engine: fetches A[i]/B[i], accumulates sum(A*B), writes result
module dot_product_core #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int MAX_LEN    = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] vec_a_base,
  input  logic [ADDR_WIDTH-1:0] vec_b_base,
  input  logic [DATA_WIDTH-1:0] vec_len,
  input  logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_WAIT_A,
    S_RD_B,
    S_WAIT_B,
    S_WRITE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   a_ptr;
  logic [ADDR_WIDTH-1:0]   b_ptr;
  logic [ADDR_WIDTH-1:0]   out_q;
  logic [IDX_W-1:0]        len_q;
  logic [IDX_W-1:0]        idx;
  logic [ACC_WIDTH-1:0]    acc;
  logic [DATA_WIDTH-1:0]   a_val;

  logic [ACC_WIDTH-1:0]    a_ext;
  logic [ACC_WIDTH-1:0]    b_ext;
  logic [ACC_WIDTH-1:0]    prod;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic [IDX_W-1:0]        idx_inc;
  logic                    len_bad;
  logic                    len_zero;
  logic                    acc_ovf;

  // Sign-extend both operands to the accumulator width; the low ACC_WIDTH bits of the
  // unsigned product then equal the signed product modulo 2^ACC_WIDTH.
  always_comb begin
    a_ext    = {{(ACC_WIDTH-DATA_WIDTH){a_val[DATA_WIDTH-1]}}, a_val};
    b_ext    = {{(ACC_WIDTH-DATA_WIDTH){rd_data[DATA_WIDTH-1]}}, rd_data};
    prod     = a_ext * b_ext;
    acc_sum  = acc + prod;
    idx_inc  = idx + IDX_W'(1);
    len_bad  = vec_len > DATA_WIDTH'(MAX_LEN);
    len_zero = vec_len == '0;
    acc_ovf  = !((&acc[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|acc[ACC_WIDTH-1:DATA_WIDTH-1]));
  end

  // Control FSM with all outputs registered; a read or write request is raised on the
  // transition into its state and held untouched until the handshake completes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      a_ptr    <= '0;
      b_ptr    <= '0;
      out_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      acc      <= '0;
      a_val    <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ovf      <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done  <= 1'b0;
            err   <= 1'b0;
            ovf   <= 1'b0;
            a_ptr <= vec_a_base;
            b_ptr <= vec_b_base;
            out_q <= out_addr;
            len_q <= vec_len[IDX_W-1:0];
            idx   <= '0;
            acc   <= '0;
            if (len_bad) begin
              // Rejected length: report immediately, never touch memory.
              err  <= 1'b1;
              done <= 1'b1;
            end else if (len_zero) begin
              state    <= S_WRITE;
              busy     <= 1'b1;
              wr_valid <= 1'b1;
              wr_addr  <= out_addr;
              wr_data  <= '0;
            end else begin
              state   <= S_RD_A;
              busy    <= 1'b1;
              rd_req  <= 1'b1;
              rd_addr <= vec_a_base;
            end
          end
        end
        S_RD_A: begin
          if (rd_gnt) begin
            rd_req <= 1'b0;
            state  <= S_WAIT_A;
          end
        end
        S_WAIT_A: begin
          if (rd_valid) begin
            a_val   <= rd_data;
            rd_req  <= 1'b1;
            rd_addr <= b_ptr;
            state   <= S_RD_B;
          end
        end
        S_RD_B: begin
          if (rd_gnt) begin
            rd_req <= 1'b0;
            state  <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (rd_valid) begin
            acc   <= acc_sum;
            idx   <= idx_inc;
            a_ptr <= a_ptr + STEP;
            b_ptr <= b_ptr + STEP;
            if (idx_inc == len_q) begin
              state    <= S_WRITE;
              wr_valid <= 1'b1;
              wr_addr  <= out_q;
              wr_data  <= acc_sum[DATA_WIDTH-1:0];
            end else begin
              state   <= S_RD_A;
              rd_req  <= 1'b1;
              rd_addr <= a_ptr + STEP;
            end
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            result   <= wr_data;
            done     <= 1'b1;
            ovf      <= acc_ovf;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_core.sv
// tb/tb_dot_product_core.sv - randomized self-checking bench for dot_product_core
module tb_dot_product_core;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] vec_a_base, vec_b_base, vec_len, out_addr;
  logic        rd_req, rd_gnt, rd_valid;
  logic [31:0] rd_addr, rd_data;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done, err, ovf;
  logic [31:0] result;

  dot_product_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACC_WIDTH(64), .MAX_LEN(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .vec_a_base(vec_a_base), .vec_b_base(vec_b_base), .vec_len(vec_len), .out_addr(out_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err), .ovf(ovf), .result(result)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // sparse word memory seen by the read port
  bit [31:0] mem [bit [31:0]];
  function automatic bit [31:0] mrd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  bit [31:0] rd_log[$];
  bit [31:0] wa_log[$];
  bit [31:0] wd_log[$];

  int        max_stall = 0;
  bit        inject = 1'b0;
  bit        pend = 1'b0, req_seen = 1'b0, wreq_seen = 1'b0;
  int        gnt_wait, val_wait, wr_wait;
  bit [31:0] pend_addr, req_addr, wreq_addr, wreq_data;

  // memory/write-sink responder with random stalls; drives 1ns after the falling edge
  initial begin
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0; wr_ready = 1'b0;
    forever begin
      @(negedge ACLK);
      #1;
      rd_gnt = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0;
      if (ARESET) begin
        pend = 1'b0; req_seen = 1'b0; wreq_seen = 1'b0;
      end else if (inject) begin
        rd_valid = 1'b1; rd_data = 32'h1234_5678; wr_ready = 1'b1; inject = 1'b0;
      end else begin
        if (pend) begin
          if (val_wait == 0) begin
            rd_valid = 1'b1; rd_data = mrd(pend_addr); pend = 1'b0;
          end else val_wait--;
        end else if (rd_req) begin
          if (!req_seen) begin
            req_seen = 1'b1; req_addr = rd_addr; gnt_wait = $urandom_range(max_stall, 0);
          end else check("rd_addr_stable", 64'(rd_addr), 64'(req_addr));
          if (gnt_wait == 0) begin
            rd_gnt = 1'b1; pend = 1'b1; pend_addr = rd_addr; req_seen = 1'b0;
            val_wait = $urandom_range(max_stall, 0);
            rd_log.push_back(rd_addr);
          end else gnt_wait--;
        end
        if (wr_valid) begin
          if (!wreq_seen) begin
            wreq_seen = 1'b1; wreq_addr = wr_addr; wreq_data = wr_data;
            wr_wait = $urandom_range(max_stall, 0);
          end else begin
            check("wr_addr_stable", 64'(wr_addr), 64'(wreq_addr));
            check("wr_data_stable", 64'(wr_data), 64'(wreq_data));
          end
          if (wr_wait == 0) begin
            wr_ready = 1'b1; wreq_seen = 1'b0;
            wa_log.push_back(wr_addr); wd_log.push_back(wr_data);
          end else wr_wait--;
        end
      end
    end
  end

  task automatic check_zero(input string p);
    check({p, "_busy"}, 64'(busy), 64'(0));
    check({p, "_done"}, 64'(done), 64'(0));
    check({p, "_err"}, 64'(err), 64'(0));
    check({p, "_ovf"}, 64'(ovf), 64'(0));
    check({p, "_result"}, 64'(result), 64'(0));
    check({p, "_rd_req"}, 64'(rd_req), 64'(0));
    check({p, "_rd_addr"}, 64'(rd_addr), 64'(0));
    check({p, "_wr_valid"}, 64'(wr_valid), 64'(0));
    check({p, "_wr_addr"}, 64'(wr_addr), 64'(0));
    check({p, "_wr_data"}, 64'(wr_data), 64'(0));
  endtask

  task automatic pulse_start(input bit [31:0] a, input bit [31:0] b, input bit [31:0] len, input bit [31:0] o);
    vec_a_base = a; vec_b_base = b; vec_len = len; out_addr = o;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic fill(input bit [31:0] a, input bit [31:0] b, input int len);
    for (int i = 0; i < len; i++) mem[a + 32'(4 * i)] = $urandom;
    for (int i = 0; i < len; i++) mem[b + 32'(4 * i)] = $urandom;
  endtask

  // one complete run compared against the plain-arithmetic model
  task automatic run(input string tag, input bit [31:0] a, input bit [31:0] b, input int len,
                     input bit [31:0] o, input bit meddle, input bit chk_lat);
    longint    sum;
    int        ai, bi, cyc, nr;
    bit        seen, exp_ovf;
    bit [31:0] exp_rd[$];
    sum = 0;
    for (int i = 0; i < len; i++) begin
      exp_rd.push_back(a + 32'(4 * i));
      exp_rd.push_back(b + 32'(4 * i));
      ai = int'(mrd(a + 32'(4 * i)));
      bi = int'(mrd(b + 32'(4 * i)));
      sum += longint'(ai) * longint'(bi);
    end
    exp_ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    pulse_start(a, b, 32'(len), o);
    if (meddle) begin
      vec_a_base = $urandom; vec_b_base = $urandom; out_addr = $urandom;
    end
    cyc = 1; seen = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (!seen && wr_valid) begin
        seen = 1'b1;
        if (chk_lat) check({tag, "_latency"}, 64'(cyc), 64'(4 * len + 1));
      end
      start = (meddle && k == 2);
      if (start) vec_len = $urandom_range(7, 1);
      @(negedge ACLK);
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    check({tag, "_result"}, 64'(result), 64'(sum[31:0]));
    check({tag, "_nreads"}, 64'(rd_log.size()), 64'(exp_rd.size()));
    nr = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < nr; i++) check({tag, "_rd_addr"}, 64'(rd_log[i]), 64'(exp_rd[i]));
    check({tag, "_nwrites"}, 64'(wa_log.size()), 64'(1));
    if (wa_log.size() > 0) begin
      check({tag, "_wr_addr"}, 64'(wa_log[0]), 64'(o));
      check({tag, "_wr_data"}, 64'(wd_log[0]), 64'(sum[31:0]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a, b;
    int        len, k;
    ARESET = 1'b1; start = 1'b0;
    vec_a_base = '0; vec_b_base = '0; vec_len = '0; out_addr = '0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    check_zero("reset");

    mem[32'h0] = 1; mem[32'h4] = 2; mem[32'h8] = 3;
    mem[32'h100] = 4; mem[32'h104] = 5; mem[32'h108] = 6;
    run("len3", 32'h0, 32'h100, 3, 32'h1000, 1'b0, 1'b1);
    check("len3_value", 64'(result), 64'(32'h20));

    mem[32'h200] = -2; mem[32'h204] = 3; mem[32'h300] = 5; mem[32'h304] = -4;
    run("signed", 32'h200, 32'h300, 2, 32'h1004, 1'b0, 1'b1);
    check("signed_value", 64'(result), 64'(32'hFFFF_FFEA));

    run("len0", 32'h0, 32'h100, 0, 32'h1008, 1'b0, 1'b1);

    rd_log.delete(); wa_log.delete(); wd_log.delete();
    pulse_start(32'h0, 32'h100, 32'd1025, 32'h100C);
    check("badlen_done", 64'(done), 64'(1));
    check("badlen_err", 64'(err), 64'(1));
    check("badlen_busy", 64'(busy), 64'(0));
    check("badlen_rd_req", 64'(rd_req), 64'(0));
    check("badlen_wr_valid", 64'(wr_valid), 64'(0));
    repeat (6) @(negedge ACLK);
    check("badlen_nreads", 64'(rd_log.size()), 64'(0));
    check("badlen_nwrites", 64'(wa_log.size()), 64'(0));
    check("badlen_err_hold", 64'(err), 64'(1));

    mem[32'h400] = 32'h7FFF_FFFF; mem[32'h500] = 2;
    run("ovf", 32'h400, 32'h500, 1, 32'h1010, 1'b0, 1'b1);
    check("ovf_value", 64'(result), 64'(32'hFFFF_FFFE));
    check("ovf_flag", 64'(ovf), 64'(1));

    max_stall = 5;
    for (int r = 0; r < 8; r++) begin
      a = (r == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      b = $urandom & 32'hFFFF_FFFC;
      len = $urandom_range(8, 1);
      fill(a, b, len);
      run("rand", a, b, len, $urandom, 1'b1, 1'b0);
    end

    // abort a run with reset while the B read is outstanding
    a = 32'h2000; b = 32'h3000;
    fill(a, b, 6);
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    pulse_start(a, b, 32'd6, 32'h4000);
    k = 0;
    while (!(pend && rd_log.size() >= 2 && rd_log.size() % 2 == 0) && k < 500) begin
      @(negedge ACLK);
      k++;
    end
    check("abort_reach_wait_b", 64'(k < 500), 64'(1));
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check_zero("abort");
    inject = 1'b1;
    repeat (4) @(negedge ACLK);
    check_zero("abort_stray");
    check("abort_nwrites", 64'(wa_log.size()), 64'(0));
    run("after_abort", a, b, 6, 32'h4000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
